// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
// Walks a 2**SELW-input mux one channel at a time. The select is held for HOLD
// cycles per channel, and the mux output is sampled on the last cycle of each
// hold window. The sampled bits are assembled into an NCH-bit frame, which is
// offered downstream with a valid/ready handshake. A scan runs once per start
// pulse, or back-to-back while cont is high.
module mux_sel_scanner #(
    parameter int NCH  = 4,
    parameter int SELW = 2,
    parameter int HOLD = 2,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cont,
    output logic [SELW-1:0] s,
    input  logic            mux_out,
    output logic [NCH-1:0]  frame,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);

    logic [1:0]      state_r;
    logic [SELW-1:0] s_r;
    logic [CNTW-1:0] cnt_r;
    logic [NCH-1:0]  capture_r;
    logic [NCH-1:0]  frame_r;
    logic            frame_valid_r;
    logic            busy_r;
    logic [NCH-1:0]  capture_next_s;

    // Capture vector with the currently selected channel replaced by the live mux bit.
    always_comb begin
        capture_next_s       = capture_r;
        capture_next_s[s_r]  = mux_out;
    end

    // Scan sequencer: select stepping, hold counting, frame assembly and handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            s_r           <= {SELW{1'b0}};
            cnt_r         <= {CNTW{1'b0}};
            capture_r     <= {NCH{1'b0}};
            frame_r       <= {NCH{1'b0}};
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_r   <= {SELW{1'b0}};
                    cnt_r <= {CNTW{1'b0}};
                    if (start) begin
                        state_r <= ST_SCAN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end else begin
                        // End of the hold window: the mux has settled, take the bit.
                        capture_r <= capture_next_s;
                        cnt_r     <= {CNTW{1'b0}};
                        if (s_r != SEL_LAST) begin
                            s_r <= s_r + SELW'(1);
                        end else begin
                            frame_r       <= capture_next_s;
                            frame_valid_r <= 1'b1;
                            s_r           <= {SELW{1'b0}};
                            state_r       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // frame_valid is always high here, so ready alone marks the transfer.
                    if (frame_ready) begin
                        frame_valid_r <= 1'b0;
                        if (cont) begin
                            state_r <= ST_SCAN;
                            s_r     <= {SELW{1'b0}};
                            cnt_r   <= {CNTW{1'b0}};
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle state.
                    state_r       <= ST_IDLE;
                    s_r           <= {SELW{1'b0}};
                    cnt_r         <= {CNTW{1'b0}};
                    frame_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign s           = s_r;
    assign frame       = frame_r;
    assign frame_valid = frame_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Testbench for mux_sel_scanner: a behavioural 4:1 mux feeds the scanner.
// Expected frames are queued when a scan is launched, and a negedge monitor
// pops and compares them on each handshake. A second instance built with
// HOLD=1 covers the single-cycle hold case.
module tb_mux_sel_scanner;

    localparam int NCH  = 4;
    localparam int SELW = 2;
    localparam int HOLD = 2;
    localparam int NH   = NCH * HOLD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            start;
    logic            cont;
    logic [SELW-1:0] s;
    logic            mux_out;
    logic [NCH-1:0]  frame;
    logic            frame_valid;
    logic            frame_ready;
    logic            busy;
    logic [NCH-1:0]  datain;

    logic            h_start;
    logic            h_cont;
    logic [SELW-1:0] h_s;
    logic            h_mux_out;
    logic [NCH-1:0]  h_frame;
    logic            h_frame_valid;
    logic            h_frame_ready;
    logic            h_busy;
    logic [NCH-1:0]  h_datain;

    // Behavioural mux4_1 models: the output follows the select combinationally.
    assign mux_out   = datain[s];
    assign h_mux_out = h_datain[h_s];

    mux_sel_scanner #(.NCH(NCH), .SELW(SELW), .HOLD(HOLD), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .s(s),
        .mux_out(mux_out), .frame(frame), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy)
    );

    mux_sel_scanner #(.NCH(NCH), .SELW(SELW), .HOLD(1), .CNTW(4)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(h_start), .cont(h_cont), .s(h_s),
        .mux_out(h_mux_out), .frame(h_frame), .frame_valid(h_frame_valid),
        .frame_ready(h_frame_ready), .busy(h_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [NCH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: on a valid&&ready cycle the next edge transfers the frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && frame_valid === 1'b1) begin
                if (frame_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_frame: got %b expected none", frame);
                    end else begin
                        check("frame", 32'(frame), 32'(exp_q.pop_front()));
                    end
                end else if (exp_q.size() != 0) begin
                    check("frame_held", 32'(frame), 32'(exp_q[0]));
                end
            end
        end
    end

    // Cycles after the launch edge: s must be k/HOLD, then frame_valid after NCH*HOLD edges.
    task automatic scan_seq();
        for (int k = 0; k < NH; k++) begin
            check("s_seq", 32'(s), k / HOLD);
            check("fv_low_in_scan", 32'(frame_valid), 32'd0);
            if (k == 0) check("busy_scan", 32'(busy), 32'd1);
            tick();
        end
        check("fv_latency", 32'(frame_valid), 32'd1);
        check("s_wrap", 32'(s), 32'd0);
    endtask

    task automatic scan_to_valid(input logic [NCH-1:0] d);
        datain = d;
        exp_q.push_back(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_seq();
    endtask

    task automatic finish_xfer(input logic exp_busy);
        frame_ready = 1'b1;
        tick();
        check("fv_after_xfer", 32'(frame_valid), 32'd0);
        check("busy_after_xfer", 32'(busy), 32'(exp_busy));
    endtask

    task automatic reset_check(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        exp_q.delete();
        check("rst_s", 32'(s), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] d;
        logic           xfer;
        logic           done;
        logic           seen;
        int             c;

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; frame_ready = 1'b1; datain = '0;
        h_start = 1'b0; h_cont = 1'b0; h_frame_ready = 1'b1; h_datain = '0;

        // 1: reset from power-up
        reset_check(2);
        tick();

        // 2: basic one-shot scan
        frame_ready = 1'b1;
        scan_to_valid(4'b1011);
        finish_xfer(1'b0);
        check("frame_kept", 32'(frame), 32'h0000000b);

        // 3: back-pressure for 5 cycles at completion
        frame_ready = 1'b0;
        scan_to_valid(4'b1011);
        for (int i = 0; i < 5; i++) begin
            check("bp_fv", 32'(frame_valid), 32'd1);
            check("bp_frame", 32'(frame), 32'h0000000b);
            check("bp_s", 32'(s), 32'd0);
            tick();
        end
        finish_xfer(1'b0);

        // 1 (DONE state): reset held 2 edges while a frame is pending
        frame_ready = 1'b0;
        scan_to_valid(4'b0111);
        reset_check(2);
        tick();

        // 4: continuous mode, second scan starts at the transfer edge
        cont = 1'b1;
        frame_ready = 1'b1;
        scan_to_valid(4'b1011);
        datain = 4'b0110;
        exp_q.push_back(4'b0110);
        tick();
        check("cont_busy", 32'(busy), 32'd1);
        check("cont_fv", 32'(frame_valid), 32'd0);
        cont = 1'b0;
        scan_seq();
        finish_xfer(1'b0);

        // 5: one-edge reset while s==2, then a clean scan
        datain = 4'b1110;
        exp_q.push_back(4'b1110);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (s != 2'd2 && c < 20) begin
            tick();
            c++;
        end
        check("reach_s2", 32'(s), 32'd2);
        reset_check(1);
        scan_to_valid(4'b1100);
        finish_xfer(1'b0);

        // 6: start pulses during SCAN and DONE are ignored
        frame_ready = 1'b0;
        datain = 4'b1001;
        exp_q.push_back(4'b1001);
        start = 1'b1;
        tick();
        for (int k = 0; k < NH; k++) begin
            start = (k % 3 == 1) ? 1'b1 : 1'b0;
            tick();
        end
        check("ign_fv", 32'(frame_valid), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_xfer(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (frame_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        check("no_queued_start", 32'(seen), 32'd0);

        // 6: HOLD=1 instance, one sample per cycle
        for (int r = 0; r < 4; r++) begin
            d = (r == 0) ? 4'b0101 : 4'($urandom);
            h_datain = d;
            h_start = 1'b1;
            tick();
            h_start = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                check("h1_s_seq", 32'(h_s), k);
                check("h1_fv_low", 32'(h_frame_valid), 32'd0);
                tick();
            end
            check("h1_fv", 32'(h_frame_valid), 32'd1);
            check("h1_frame", 32'(h_frame), 32'(d));
            tick();
            check("h1_idle", 32'(h_busy), 32'd0);
        end

        // Randomized frames with random back-pressure
        for (int r = 0; r < 25; r++) begin
            d = 4'($urandom);
            datain = d;
            exp_q.push_back(d);
            frame_ready = 1'($urandom_range(0, 1));
            start = 1'b1;
            tick();
            start = 1'b0;
            done = 1'b0;
            c = 0;
            while (!done && c < 200) begin
                frame_ready = 1'($urandom_range(0, 1));
                xfer = frame_valid && frame_ready;
                tick();
                c++;
                if (xfer) done = 1'b1;
            end
            check("rand_xfer_done", 32'(done), 32'd1);
            check("rand_idle", 32'(busy), 32'd0);
        end

        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
